// File: rtl/tpu_pkg.sv
// Shared types and sizing for the TPU weight-load path.
package tpu_pkg;

    localparam int unsigned WEIGHT_W    = 8;
    localparam int unsigned WFIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_STREAM,
        LD_DONE
    } ld_state_t;

endpackage

// File: rtl/weight_credit_counter.sv
// Occupancy tracker for one weight FIFO: counts issued pushes against observed pops,
// saturating at zero and flagging (sticky) any pop seen while the FIFO is empty.
module weight_credit_counter
    import tpu_pkg::*;
#(
    parameter int unsigned DEPTH = WFIFO_DEPTH,
    parameter int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [OCC_W-1:0] occ,
    output logic             has_space,
    output logic             uflow
);

    logic [OCC_W-1:0] occ_q;
    logic             uflow_q;

    // Simultaneous inc/dec cancel; a pop on an empty FIFO never wraps the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q   <= '0;
            uflow_q <= 1'b0;
        end else begin
            if (dec && (occ_q == '0)) begin
                uflow_q <= 1'b1;
            end
            if (inc && !dec) begin
                occ_q <= occ_q + OCC_W'(1);
            end else if (dec && !inc && (occ_q != '0)) begin
                occ_q <= occ_q - OCC_W'(1);
            end
        end
    end

    assign occ       = occ_q;
    assign has_space = (occ_q < OCC_W'(DEPTH));
    assign uflow     = uflow_q;

endmodule

// File: rtl/weight_stream_loader.sv
// Streams DDR weight bytes into the per-column MMU weight FIFOs in row-major,
// column-ascending order, never pushing into a FIFO whose tracked occupancy is full.
module weight_stream_loader
    import tpu_pkg::*;
#(
    parameter int unsigned N_COLS = 2,
    parameter int unsigned DEPTH  = WFIFO_DEPTH,
    parameter int unsigned ROWS_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ROWS_W-1:0]   cmd_rows,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WEIGHT_W-1:0] in_data,
    output logic [N_COLS-1:0]   fifo_push,
    output logic [WEIGHT_W-1:0] fifo_data,
    input  logic [N_COLS-1:0]   fifo_pop,
    output logic                busy,
    output logic                done,
    output logic                err_uflow
);

    localparam int unsigned COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    ld_state_t           state_q;
    logic [COL_W-1:0]    col_q;
    logic [ROWS_W-1:0]   row_q;
    logic [ROWS_W-1:0]   rows_q;
    logic [N_COLS-1:0]   fifo_push_q;
    logic [WEIGHT_W-1:0] fifo_data_q;
    logic                done_q;

    logic [N_COLS-1:0]   inc;
    logic [N_COLS-1:0]   space;
    logic [N_COLS-1:0]   uflow;
    logic [OCC_W-1:0]    occ [N_COLS];
    logic                accept;
    logic                last_col;
    logic                last_row;

    assign cmd_ready = (state_q == LD_IDLE);
    assign busy      = (state_q == LD_STREAM);
    assign in_ready  = busy && space[col_q];
    assign accept    = in_valid && in_ready;
    assign last_col  = (col_q == COL_W'(N_COLS - 1));
    assign last_row  = (row_q == (rows_q - ROWS_W'(1)));
    assign inc       = accept ? (N_COLS'(1) << col_q) : '0;

    // Credits are taken at accept time, one cycle ahead of the registered push.
    for (genvar c = 0; c < N_COLS; c++) begin : g_col
        weight_credit_counter #(
            .DEPTH (DEPTH),
            .OCC_W (OCC_W)
        ) u_credit (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc[c]),
            .dec       (fifo_pop[c]),
            .occ       (occ[c]),
            .has_space (space[c]),
            .uflow     (uflow[c])
        );

        occ_bound_a: assert property (@(posedge clk) disable iff (rst)
            occ[c] <= OCC_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LD_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            rows_q      <= '0;
            fifo_push_q <= '0;
            fifo_data_q <= '0;
            done_q      <= 1'b0;
        end else begin
            fifo_push_q <= inc;
            done_q      <= 1'b0;
            if (accept) begin
                fifo_data_q <= in_data;
            end
            case (state_q)
                LD_IDLE: begin
                    if (cmd_valid) begin
                        rows_q <= cmd_rows;
                        col_q  <= '0;
                        row_q  <= '0;
                        if (cmd_rows == '0) begin
                            state_q <= LD_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= LD_STREAM;
                        end
                    end
                end
                LD_STREAM: begin
                    if (accept) begin
                        if (last_col) begin
                            col_q <= '0;
                            row_q <= row_q + ROWS_W'(1);
                            // done lines up with the push of the final byte
                            if (last_row) begin
                                state_q <= LD_DONE;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            col_q <= col_q + COL_W'(1);
                        end
                    end
                end
                LD_DONE: begin
                    state_q <= LD_IDLE;
                end
                default: begin
                    state_q <= LD_IDLE;
                end
            endcase
        end
    end

    assign fifo_push = fifo_push_q;
    assign fifo_data = fifo_data_q;
    assign done      = done_q;
    assign err_uflow = |uflow;

endmodule
